// File: rtl/mux_8to1.sv
// 8:1 bit multiplexer with a combinational output and an enable-gated
// registered copy that also tracks the captured select and counts output toggles.
module mux_8to1 #(
    parameter int   CNT_W = 4,
    parameter logic RST_Y = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       s,
    input  logic [7:0]       d,
    input  logic             en,
    output logic             y,
    output logic             y_q,
    output logic [2:0]       s_q,
    output logic             valid,
    output logic [CNT_W-1:0] tog_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic change;

    // Every select code maps to a data bit, so y is never X for known inputs.
    assign y = d[s];

    // A capture toggles the count only when it alters y_q and the count is not saturated.
    assign change = en && (y != y_q) && (tog_cnt != CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= RST_Y;
            s_q     <= 3'b000;
            valid   <= 1'b0;
            tog_cnt <= '0;
        end else begin
            if (en) begin
                y_q   <= y;
                s_q   <= s;
                valid <= 1'b1;
            end
            if (change) begin
                tog_cnt <= tog_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_8to1.sv
// Directed self-checking bench for mux_8to1: combinational and registered
// sweeps, enable hold, toggle saturation, async reset and same-value captures.
module tb_mux_8to1;

    logic       clk;
    logic       rst_n;
    logic [2:0] s;
    logic [7:0] d;
    logic       en;
    logic       y;
    logic       y_q;
    logic [2:0] s_q;
    logic       valid;
    logic [3:0] tog_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] sweep_exp;
    logic [3:0] exp_cnt;

    mux_8to1 #(.CNT_W(4), .RST_Y(1'b0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s       (s),
        .d       (d),
        .en      (en),
        .y       (y),
        .y_q     (y_q),
        .s_q     (s_q),
        .valid   (valid),
        .tog_cnt (tog_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_y_q"}, y_q, 0);
        check({tag, "_s_q"}, s_q, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_tog"}, tog_cnt, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        s     = 3'd0;
        d     = 8'h00;
        #2;
        check_reset_state("reset");

        // Clocks with en high while in reset must not capture.
        en = 1'b1;
        d  = 8'hFF;
        tick();
        tick();
        check_reset_state("reset_hold");
        check("reset_y_follows", y, 1);
        en = 1'b0;
        d  = 8'h00;
        release_reset();

        // Combinational sweep with en low: y follows d[s], registers untouched.
        d = 8'b10010101;
        sweep_exp = 8'b10010101;
        for (int i = 0; i < 8; i++) begin
            s = i[2:0];
            #15;
            check($sformatf("comb_y_s%0d", i), y, sweep_exp[i]);
        end
        check("comb_no_capture_valid", valid, 0);
        check("comb_no_capture_y_q", y_q, 0);

        // Registered sweep: expected sequence 1,0,1,0,1,0,0,1.
        @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s = i[2:0];
            tick();
            check($sformatf("reg_y_q_s%0d", i), y_q, sweep_exp[i]);
            check($sformatf("reg_s_q_s%0d", i), s_q, i);
            check($sformatf("reg_valid_s%0d", i), valid, 1);
        end
        check("reg_sweep_tog", tog_cnt, 7);

        // Enable hold: capture y_q=1 at s=0, then freeze with s=1.
        s = 3'd0;
        tick();
        check("hold_capture_y_q", y_q, 1);
        check("hold_capture_tog", tog_cnt, 7);
        en = 1'b0;
        s  = 3'd1;
        #1;
        check("hold_y", y, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold_y_q_%0d", i), y_q, 1);
            check($sformatf("hold_s_q_%0d", i), s_q, 0);
            check($sformatf("hold_tog_%0d", i), tog_cnt, 7);
        end

        // Async reset mid-cycle from y_q=1, tog_cnt=3, valid=1.
        rst_n = 1'b0;
        #1;
        release_reset();
        d  = 8'b00000001;
        en = 1'b1;
        s  = 3'd0;
        tick();
        s = 3'd1;
        tick();
        s = 3'd0;
        tick();
        check("pre_rst_y_q", y_q, 1);
        check("pre_rst_tog", tog_cnt, 3);
        check("pre_rst_valid", valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        check("async_rst_y", y, 1);
        s = 3'd1;
        #1;
        check("async_rst_y_s1", y, 0);
        tick();
        check_reset_state("async_rst_discard");
        release_reset();

        // Toggle saturation: alternate s between 0 and 1 with d[0]=1, d[1]=0.
        d  = 8'b00000001;
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s = (i % 2 == 0) ? 3'd0 : 3'd1;
            tick();
            exp_cnt = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            check($sformatf("sat_tog_%0d", i), tog_cnt, exp_cnt);
        end
        check("sat_final", tog_cnt, 15);

        // First capture equal to RST_Y does not count as a change.
        rst_n = 1'b0;
        #1;
        release_reset();
        d = 8'h00;
        s = 3'd5;
        tick();
        check("first_same_valid", valid, 1);
        check("first_same_tog", tog_cnt, 0);
        check("first_same_s_q", s_q, 5);

        // Same-value captures with d=FF: one change then no more.
        rst_n = 1'b0;
        #1;
        release_reset();
        d = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            s = i[2:0];
            tick();
            check($sformatf("same_y_q_s%0d", i), y_q, 1);
            check($sformatf("same_tog_s%0d", i), tog_cnt, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_8to1.md
MUX_8TO1 -- requirements
Module: mux_8to1

Interface
REQ-001 Parameter CNT_W, default 4: width of the y_q toggle counter; legal range 1..16.
REQ-002 Parameter RST_Y, default 1'b0: reset value of y_q.
REQ-003 Reset is asynchronous and active-low, and there is one clock.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port s, input, 3 bits: select; picks data bit d[s].
REQ-007 Port d, input, 8 bits: data inputs d[0]..d[7].
REQ-008 Port en, input, 1 bit: capture enable for the registered path.
REQ-009 Port y, output, 1 bit: combinational mux output.
REQ-010 Port y_q, output, 1 bit: registered mux output.
REQ-011 Port s_q, output, 3 bits: select value captured with y_q.
REQ-012 Port valid, output, 1 bit: high once y_q holds a captured value.
REQ-013 Port tog_cnt, output, CNT_W bits: count of y_q value changes, saturating.

Function
REQ-014 The block SHALL drive y = d[s] combinationally at all times, with zero-cycle latency, independent of clk, rst_n and en.
REQ-015 All select values 0..7 SHALL be decoded; there are no don't-care codes and no X propagation for known inputs.
REQ-016 On a rising clk edge with en=1, y_q SHALL take d[s], s_q SHALL take s, and valid SHALL go to 1; latency from inputs to y_q is one cycle.
REQ-017 On a rising clk edge with en=0, y_q, s_q, valid and tog_cnt SHALL hold their values.
REQ-018 When a capture changes the value of y_q, tog_cnt SHALL increment by 1.
REQ-019 tog_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-020 A capture that writes the same value into y_q SHALL leave tog_cnt unchanged.
REQ-021 The first capture after reset SHALL count as a change only if d[s] differs from RST_Y.
REQ-022 Changes on d or s between clock edges SHALL affect only y, never the registered outputs.
REQ-023 There is no internal state machine; the registered path is a single enable-gated register stage.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for clk, force y_q=RST_Y, s_q=3'b000, valid=0 and tog_cnt=0.
REQ-025 While rst_n=0, the registered outputs SHALL hold their reset values regardless of en or clk.
REQ-026 y SHALL continue to follow d[s] during reset.
REQ-027 Reset asserted mid-operation SHALL discard any pending capture.
REQ-028 The first capture SHALL occur on the first rising edge with en=1 after rst_n rises.
REQ-029 Outputs SHALL be free of glitches attributable to reset release when rst_n is released synchronously to clk.

Verification
REQ-030 Combinational sweep: with d=8'b10010101 and s stepped through 0..7, 15 ns per step, y SHALL read 1,0,1,0,1,0,0,1.
REQ-031 Registered sweep: with the same d, en=1, s stepped once per clock, y_q SHALL reproduce the same sequence one cycle late, s_q SHALL track s one cycle late, and valid SHALL be 1 from the first edge.
REQ-032 Enable hold: after capturing y_q=1 at s=0, set en=0 and s=1; y SHALL be 0 while y_q stays 1, s_q stays 0 and tog_cnt is unchanged over 5 clocks.
REQ-033 Toggle saturation: with CNT_W=4, d=8'b00000001, en=1, alternate s between 0 and 1 for 20 clocks; tog_cnt SHALL reach 15 and remain 15.
REQ-034 Async reset: after nonzero state (y_q=1, tog_cnt=3, valid=1), drive rst_n low between clock edges; all registered outputs SHALL reset immediately, and y SHALL keep equal to d[s].
REQ-035 Same-value capture: with d=8'hFF, hold en=1 while sweeping s; y_q SHALL be 1, and tog_cnt SHALL be 1 after the first capture (RST_Y=0) and stay 1.
